// File: rtl/instr_mem_stream.sv
// Instruction memory with a valid/ready fetch port, a word-wide load port and
// address fault reporting. A synchronous clear starts a one-word-per-cycle
// zeroing sweep; fetch responses are registered with one cycle of latency.
module instr_mem_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic                  clock,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [1:0]            instr_fault,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Range bounds carry one extra bit so BASE_ADDR + DEPTH*4 cannot wrap.
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + ((ADDR_WIDTH+1)'(DEPTH) << 2);

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        cnt_q;
  logic                    instr_valid_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic [1:0]              fault_q;
  logic                    load_err_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    fetch_in_range;
  logic                    fetch_aligned;
  logic                    fetch_ok;
  logic [IDX_W-1:0]        fetch_idx;
  logic                    load_in_range;
  logic                    load_aligned;
  logic                    load_ok;
  logic [IDX_W-1:0]        load_idx;
  logic                    fetch_fire;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= BASE_EXT) && ({1'b0, a} < LIMIT_EXT);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // Address decode shared by the fetch and load ports.
  always_comb begin
    fetch_in_range = in_range(fetch_addr);
    fetch_aligned  = (fetch_addr[1:0] == 2'b00);
    fetch_ok       = fetch_in_range && fetch_aligned;
    fetch_idx      = word_idx(fetch_addr);
    load_in_range  = in_range(load_addr);
    load_aligned   = (load_addr[1:0] == 2'b00);
    load_ok        = load_in_range && load_aligned;
    load_idx       = word_idx(load_addr);
  end

  assign busy        = (state_q == ST_SWEEP);
  assign fetch_ready = (state_q == ST_RUN) && (!instr_valid_q || instr_ready);
  assign fetch_fire  = fetch_valid && fetch_ready;

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_fault = fault_q;
  assign load_err    = load_err_q;

  // Sweep/run sequencing, fetch response register and load error pulse.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q       <= ST_SWEEP;
      cnt_q         <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      fault_q       <= 2'b00;
      load_err_q    <= 1'b0;
    end else begin
      load_err_q <= load_en && ((state_q == ST_SWEEP) || !load_ok);
      case (state_q)
        ST_SWEEP: begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fetch_fire) begin
            instr_valid_q <= 1'b1;
            if (fetch_ok) begin
              instr_q <= mem_q[fetch_idx];
              fault_q <= 2'b00;
            end else begin
              instr_q <= '0;
              fault_q <= {!fetch_aligned, !fetch_in_range};
            end
          end else if (instr_ready) begin
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_SWEEP;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Storage: sweep zeroes one word per cycle, loads land only in RUN.
  // The fetch read above sees the pre-edge word, giving read-before-write.
  always_ff @(posedge clock) begin
    if (!clear) begin
      if (state_q == ST_SWEEP) begin
        mem_q[cnt_q] <= '0;
      end else if (load_en && load_ok) begin
        mem_q[load_idx] <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_stream.sv
// Scoreboard bench for instr_mem_stream: stimulus pushes expected responses,
// a forked monitor pops and compares on every response handshake.
module tb_instr_mem_stream;

  logic        clock = 1'b0;
  logic        clear;
  logic        busy;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [1:0]  instr_fault;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_err;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n;

  always #5 clock = ~clock;

  instr_mem_stream dut (
    .clock       (clock),
    .clear       (clear),
    .busy        (busy),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_addr  (fetch_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_fault (instr_fault),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_err    (load_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    sb.delete();
  endtask

  // Presents a request, waits (bounded) for acceptance, records the expected response.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ef);
    int   t;
    exp_t e;
    fetch_valid = 1'b1;
    fetch_addr  = a;
    t = 0;
    @(negedge clock);
    while (!fetch_ready && t < 50) begin
      t++;
      @(negedge clock);
    end
    chk("fetch_accept", 64'(fetch_ready), 64'd1);
    if (fetch_ready) begin
      e.instr = ei;
      e.fault = ef;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic exp_err);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clock);
    #1;
    load_en = 1'b0;
    chk("load_err_pulse", 64'(load_err), 64'(exp_err));
    @(posedge clock);
    #1;
    chk("load_err_end", 64'(load_err), 64'd0);
  endtask

  // Steps edge by edge while busy; optionally attempts a load mid-sweep.
  task automatic run_sweep(input bit with_load, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      if (with_load && cnt == 50) begin
        load_en   = 1'b1;
        load_addr = 32'h0040_0010;
        load_data = 32'h1111_1111;
      end else begin
        load_en = 1'b0;
      end
      if (cnt == 10) chk("sweep_fetch_ready", 64'(fetch_ready), 64'd0);
      if (with_load && cnt == 51) chk("sweep_load_err", 64'(load_err), 64'd1);
      if (with_load && cnt == 52) chk("sweep_load_err_end", 64'(load_err), 64'd0);
      @(posedge clock);
      #1;
      cnt++;
    end
    load_en = 1'b0;
  endtask

  initial begin
    clear       = 1'b0;
    fetch_valid = 1'b0;
    fetch_addr  = '0;
    instr_ready = 1'b1;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;

    fork
      forever begin
        @(posedge clock);
        cyc++;
      end
      forever begin
        @(negedge clock);
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_response: got instr %0h fault %0h with no expected entry",
                     instr, instr_fault);
          end else begin
            mon_e = sb.pop_front();
            chk("resp_instr", 64'(instr), 64'(mon_e.instr));
            chk("resp_fault", 64'(instr_fault), 64'(mon_e.fault));
            pop_cyc.push_back(cyc);
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    settle(2);

    // Reset state and sweep length
    do_clear();
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_fault", 64'(instr_fault), 64'd0);
    chk("rst_load_err", 64'(load_err), 64'd0);
    run_sweep(1'b0, n);
    chk("sweep_len", 64'(n), 64'd256);
    chk("run_fetch_ready", 64'(fetch_ready), 64'd1);
    do_fetch(32'h0040_0000, 32'h0, 2'b00);
    do_fetch(32'h0040_03FC, 32'h0, 2'b00);
    fetch_valid = 1'b0;
    settle(2);

    // Load then back-to-back fetch
    do_load(32'h0040_0000, 32'h3010_0001, 1'b0);
    do_load(32'h0040_0004, 32'h3610_8000, 1'b0);
    do_load(32'h0040_0008, 32'h321F_FFF1, 1'b0);
    pop_cyc.delete();
    do_fetch(32'h0040_0000, 32'h3010_0001, 2'b00);
    do_fetch(32'h0040_0004, 32'h3610_8000, 2'b00);
    do_fetch(32'h0040_0008, 32'h321F_FFF1, 2'b00);
    fetch_valid = 1'b0;
    settle(3);
    chk("b2b_count", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
      chk("b2b_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
    end

    // Faults
    do_fetch(32'h0040_0400, 32'h0, 2'b01);
    do_fetch(32'h0040_0002, 32'h0, 2'b10);
    do_fetch(32'h003F_FFFF, 32'h0, 2'b11);
    fetch_valid = 1'b0;
    settle(2);
    do_load(32'h0040_0400, 32'hCAFE_F00D, 1'b1);
    do_load(32'h0040_0006, 32'hCAFE_F00D, 1'b1);
    do_fetch(32'h0040_0000, 32'h3010_0001, 2'b00);
    do_fetch(32'h0040_0004, 32'h3610_8000, 2'b00);
    fetch_valid = 1'b0;
    settle(2);

    // Back-pressure
    instr_ready = 1'b0;
    do_fetch(32'h0040_0004, 32'h3610_8000, 2'b00);
    fetch_addr = 32'h0040_0008;
    repeat (3) begin
      @(negedge clock);
      chk("bp_instr_hold", 64'(instr), 64'h3610_8000);
      chk("bp_valid_hold", 64'(instr_valid), 64'd1);
      chk("bp_fetch_ready", 64'(fetch_ready), 64'd0);
    end
    @(posedge clock);
    #1;
    instr_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_accept", 64'(fetch_ready), 64'd1);
    if (fetch_ready) begin
      mon_e.instr = 32'h321F_FFF1;
      mon_e.fault = 2'b00;
      sb.push_back(mon_e);
    end
    @(posedge clock);
    #1;
    fetch_valid = 1'b0;
    settle(2);

    // Same-edge load and fetch: fetch returns old word
    load_en   = 1'b1;
    load_addr = 32'h0040_0008;
    load_data = 32'hDEAD_BEEF;
    do_fetch(32'h0040_0008, 32'h321F_FFF1, 2'b00);
    load_en = 1'b0;
    chk("collide_load_err", 64'(load_err), 64'd0);
    do_fetch(32'h0040_0008, 32'hDEAD_BEEF, 2'b00);
    fetch_valid = 1'b0;
    settle(3);

    // Clear with a pending response, then re-clear mid-sweep
    instr_ready = 1'b0;
    do_fetch(32'h0040_0000, 32'h3010_0001, 2'b00);
    fetch_valid = 1'b0;
    chk("pending_valid", 64'(instr_valid), 64'd1);
    do_clear();
    chk("clr_drop_valid", 64'(instr_valid), 64'd0);
    chk("clr_busy", 64'(busy), 64'd1);
    chk("clr_instr", 64'(instr), 64'd0);
    instr_ready = 1'b1;
    settle(100);
    chk("sweep100_busy", 64'(busy), 64'd1);
    do_clear();
    run_sweep(1'b1, n);
    chk("resweep_len", 64'(n), 64'd256);
    do_fetch(32'h0040_0010, 32'h0, 2'b00);
    do_fetch(32'h0040_0000, 32'h0, 2'b00);
    do_fetch(32'h0040_0008, 32'h0, 2'b00);
    fetch_valid = 1'b0;
    settle(3);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
